btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 203 ++++++++++++++++++++
 tb/tb_btn_conditioner.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel button synchroniser, debouncer, edge detector
// and auto-repeat generator.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active high
//   btn_in[C]      raw asynchronous button levels (1 = pressed)
//   mode[2]        event select: 00 press, 01 release, 10 both, 11 none
//   repeat_en      enables auto-repeat on all channels
//   level_out[C]   debounced level
//   press_pulse[C] one-cycle pulse on a debounced 0->1
//   release_pulse[C] one-cycle pulse on a debounced 1->0
//   event_pulse[C] mode-selected edges ORed with repeat pulses (one cycle after the edge pulses)
//   any_event      OR of event_pulse

// One button channel. event_d_o is the next-state value of the channel's
// event_pulse bit; the top registers it alongside the any_event reduction.
module btn_conditioner_chan #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    input  logic [1:0] mode_i,
    input  logic       repeat_en_i,
    output logic       level_o,
    output logic       press_o,
    output logic       release_o,
    output logic       event_d_o
);
    localparam int SW   = $clog2(STABLE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [SW-1:0] STAB_LAST   = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RPT} rpt_state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [SW-1:0]          stab_q, stab_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   rise, fall;
    rpt_state_e             state_q, state_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   rpt;

    assign synced = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive cycles where the synced input disagrees
    // with the debounced level; flip on the cycle the count would reach
    // STABLE_CYCLES. Edge pulses are registered with the level so they line
    // up with the first cycle showing the new value.
    always_comb begin
        stab_d    = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        if (synced != level_q) begin
            if (stab_q == STAB_LAST) begin
                level_d   = ~level_q;
                press_d   = ~level_q;
                release_d = level_q;
                rise      = ~level_q;
                fall      = level_q;
            end else begin
                stab_d = stab_q + SW'(1);
            end
        end
    end

    // Repeat FSM. Entered on the same edge that raises press_pulse, so in
    // the press_pulse cycle the counter reads 0 and the k-th cycle after it
    // reads k. rpt is combinational; the registered event lands one cycle
    // later, i.e. REPEAT_DELAY cycles after press_pulse.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q + RW'(1);
        rpt     = 1'b0;
        case (state_q)
            IDLE: begin
                rcnt_d = '0;
                if (rise && repeat_en_i) state_d = WAIT;
            end
            WAIT: begin
                if (fall || !repeat_en_i) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == DELAY_LAST) begin
                    rpt     = 1'b1;
                    state_d = RPT;
                    rcnt_d  = '0;
                end
            end
            RPT: begin
                if (fall || !repeat_en_i) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == PERIOD_LAST) begin
                    rpt    = 1'b1;
                    rcnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    // Press counts in modes 00/10, release in 01/10; mode 11 mutes everything.
    always_comb begin
        event_d_o = 1'b0;
        if (mode_i != 2'b11)
            event_d_o = (press_q & ~mode_i[0]) | (release_q & (mode_i[0] ^ mode_i[1])) | rpt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            stab_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= IDLE;
            rcnt_q    <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            stab_q    <= stab_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

module btn_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [1:0]          mode,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] event_pulse,
    output logic                any_event
);
    logic [CHANNELS-1:0] event_d, event_q;
    logic                any_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        btn_conditioner_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .btn_i      (btn_in[g]),
            .mode_i     (mode),
            .repeat_en_i(repeat_en),
            .level_o    (level_out[g]),
            .press_o    (press_pulse[g]),
            .release_o  (release_pulse[g]),
            .event_d_o  (event_d[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_q <= '0;
            any_q   <= 1'b0;
        end else begin
            event_q <= event_d;
            any_q   <= |event_d;
        end
    end

    assign event_pulse = event_q;
    assign any_event   = any_q;
endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
    localparam int CH = 4;
    localparam int S  = 2;
    localparam int ST = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] btn_in = '0;
    logic [1:0]    mode = 2'b00;
    logic          repeat_en = 1'b0;
    logic [CH-1:0] level_out, press_pulse, release_pulse, event_pulse;
    logic          any_event;

    int checks = 0;
    int failures = 0;

    btn_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(S), .STABLE_CYCLES(ST),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .mode(mode), .repeat_en(repeat_en),
        .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .event_pulse(event_pulse), .any_event(any_event)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference model: inputs delayed through a queue of S samples, a run
    // length of disagreeing samples, and repeat pulses predicted from the
    // press timestamp (press + RD + k*RP) until release or repeat_en drops.
    logic [CH-1:0] e_level, e_press, e_release, e_event;
    logic          e_any;
    int            run[CH];
    bit            armed[CH];
    int            pedge[CH];
    int            n;
    logic [CH-1:0] mq[$];

    function automatic void model_reset();
        e_level = '0; e_press = '0; e_release = '0; e_event = '0; e_any = 1'b0;
        for (int c = 0; c < CH; c++) begin
            run[c] = 0; armed[c] = 1'b0; pedge[c] = 0;
        end
        n = 0;
        mq.delete();
        for (int i = 0; i < S; i++) mq.push_back('0);
    endfunction

    function automatic void model_step(input logic [CH-1:0] b, input logic [1:0] md, input logic ren);
        logic [CH-1:0] d, pp, pr;
        bit rise, fall, fire;
        int k;
        d = mq.pop_front();
        mq.push_back(b);
        pp = e_press;
        pr = e_release;
        for (int c = 0; c < CH; c++) begin
            rise = 1'b0; fall = 1'b0; fire = 1'b0;
            if (d[c] != e_level[c]) begin
                run[c]++;
                if (run[c] == ST) begin
                    run[c] = 0;
                    if (e_level[c]) fall = 1'b1; else rise = 1'b1;
                    e_level[c] = ~e_level[c];
                end
            end else begin
                run[c] = 0;
            end
            if (armed[c]) begin
                if (fall || !ren) armed[c] = 1'b0;
                else begin
                    k = n - pedge[c] - RD;
                    if (k >= 0 && (k % RP) == 0) fire = 1'b1;
                end
            end
            if (rise && ren) begin
                armed[c] = 1'b1;
                pedge[c] = n;
            end
            e_press[c]   = rise;
            e_release[c] = fall;
            e_event[c]   = (md != 2'b11) &&
                           ((pp[c] && md[0] == 1'b0) ||
                            (pr[c] && (md == 2'b01 || md == 2'b10)) || fire);
        end
        e_any = |e_event;
        n++;
    endfunction

    function automatic logic [4*CH:0] obs_vec();
        return {level_out, press_pulse, release_pulse, event_pulse, any_event};
    endfunction

    function automatic logic [4*CH:0] exp_vec();
        return {e_level, e_press, e_release, e_event, e_any};
    endfunction

    // One clock: inputs are already set (at the falling edge), the DUT and
    // model both take them on the rising edge, and we return at the next
    // falling edge ready for sampling.
    task automatic tick();
        @(posedge clk);
        model_step(btn_in, mode, repeat_en);
        @(negedge clk);
    endtask

    task automatic settle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = '0; mode = 2'b00; repeat_en = 1'b0;
        repeat (3) @(negedge clk);
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", obs_vec());
        end
        checks++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_press();
        int pk, lk, ek;
        pk = -1; lk = -1; ek = -1;
        mode = 2'b00; repeat_en = 1'b0; btn_in = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL press_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (pk < 0 && press_pulse[0]) pk = i;
            if (lk < 0 && level_out[0]) lk = i;
            if (ek < 0 && event_pulse[0]) ek = i;
        end
        if (pk !== 6 || lk !== 6 || ek !== 7) begin
            failures++;
            $display("FAIL press_latency press=%0d level=%0d event=%0d exp=6/6/7", pk, lk, ek);
        end
        checks++;
        btn_in = '0;
        settle(12);
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b0101;
        mode = 2'b00;
        for (int i = 0; i < 14; i++) begin
            btn_in[1] = (i < 4) ? pat[i] : 1'b0;
            tick();
            if ({level_out[1], press_pulse[1], release_pulse[1]} !== 3'b000 ||
                obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL bounce i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_both_edges();
        int nev, nrel;
        bit any_bad;
        nev = 0; nrel = 0; any_bad = 1'b0;
        mode = 2'b10; repeat_en = 1'b0;
        for (int i = 0; i < 24; i++) begin
            btn_in[2] = (i < 10);
            tick();
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL both_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (event_pulse[2]) begin
                nev++;
                if (any_event !== 1'b1) any_bad = 1'b1;
            end
            if (release_pulse[2]) nrel++;
        end
        if (nev != 2 || nrel != 1 || any_bad) begin
            failures++;
            $display("FAIL both_edges events=%0d releases=%0d any_bad=%0d exp=2/1/0", nev, nrel, any_bad);
        end
        checks++;
        mode = 2'b00;
    endtask

    task automatic test_repeat();
        logic [29:0] got_mask, exp_mask;
        int found, after_rel;
        bit rel_seen;
        got_mask = '0; exp_mask = '0;
        exp_mask[1] = 1'b1;
        for (int k = RD; k < 30; k += RP) exp_mask[k] = 1'b1;
        mode = 2'b00; repeat_en = 1'b1; btn_in[3] = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (press_pulse[3]) found = 1;
        end
        if (!found) begin
            failures++;
            $display("FAIL repeat_press_timeout got=0 exp=press");
        end
        checks++;
        for (int k = 1; k < 30; k++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL repeat_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            checks++;
            got_mask[k] = event_pulse[3];
        end
        if (got_mask !== exp_mask) begin
            failures++;
            $display("FAIL repeat_offsets got=%b exp=%b", got_mask, exp_mask);
        end
        checks++;
        btn_in[3] = 1'b0;
        rel_seen = 1'b0; after_rel = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL repeat_release_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (release_pulse[3]) rel_seen = 1'b1;
            if (rel_seen && event_pulse[3]) after_rel++;
        end
        if (!rel_seen || after_rel != 0) begin
            failures++;
            $display("FAIL repeat_stop rel_seen=%0d extra=%0d exp=1/0", rel_seen, after_rel);
        end
        checks++;
    endtask

    task automatic test_repeat_late();
        int nev;
        nev = 0;
        mode = 2'b00; repeat_en = 1'b0; btn_in[0] = 1'b1;
        settle(8);
        repeat_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL late_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (event_pulse[0]) nev++;
        end
        if (nev != 0) begin
            failures++;
            $display("FAIL repeat_late events=%0d exp=0", nev);
        end
        checks++;
        btn_in = '0; repeat_en = 1'b0;
        settle(12);
    endtask

    task automatic test_simultaneous();
        logic [CH-1:0] seen;
        int found;
        mode = 2'b11; repeat_en = 1'b0; btn_in = 4'b0101;
        found = 0; seen = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (press_pulse != '0) begin found = 1; seen = press_pulse; end
        end
        if (seen !== 4'b0101) begin
            failures++;
            $display("FAIL simul_press got=%b exp=0101", seen);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (press_pulse !== 4'b0000 || event_pulse !== 4'b0000 || any_event !== 1'b0) begin
                failures++;
                $display("FAIL simul_mute press=%b event=%b any=%b exp=0/0/0", press_pulse, event_pulse, any_event);
            end
            checks++;
        end
        btn_in = '0;
        settle(12);
        mode = 2'b00;
    endtask

    task automatic test_reset_mid();
        int found, pk;
        mode = 2'b00; repeat_en = 1'b1; btn_in[1] = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (press_pulse[1]) found = 1;
        end
        settle(4);
        #2;
        rst = 1'b1;
        #1;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", obs_vec());
        end
        checks++;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pk = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (pk < 0 && press_pulse[1]) pk = i;
        end
        if (pk !== 6) begin
            failures++;
            $display("FAIL reset_press_latency got=%0d exp=6", pk);
        end
        checks++;
        btn_in = '0; repeat_en = 1'b0;
        settle(12);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(11) == 0) btn_in[c] = ~btn_in[c];
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) repeat_en = ~repeat_en;
            tick();
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press();
        test_bounce();
        test_both_edges();
        test_repeat();
        test_repeat_late();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
